// File: rtl/acq_controller_if.sv
// Reader/RAM side bus of the acquisition controller: the disc reader word
// stream coming in and the acquisition RAM write port going out.
interface acq_controller_if #(
  parameter int BITS      = 16,
  parameter int ADDR_BITS = 19
) ();
  logic                 MDR_RUN;
  logic [BITS-1:0]      MDR_DATA;
  logic                 MDR_WRITE;
  logic [ADDR_BITS-1:0] RAM_ADDR;
  logic [BITS-1:0]      RAM_DATA;
  logic                 RAM_WE;

  modport master (
    output MDR_RUN, RAM_ADDR, RAM_DATA, RAM_WE,
    input  MDR_DATA, MDR_WRITE
  );

  modport slave (
    input  MDR_RUN, RAM_ADDR, RAM_DATA, RAM_WE,
    output MDR_DATA, MDR_WRITE
  );
endinterface

// File: rtl/acq_controller.sv
// Sequences one disc acquisition: arm on START, optionally wait for index,
// stream reader words into RAM, stop on index limit / RAM full / ABORT.
module acq_controller #(
  parameter int BITS      = 16,
  parameter int ADDR_BITS = 19,
  parameter int IDX_BITS  = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 WAIT_INDEX,
  input  logic [IDX_BITS-1:0]  INDEX_LIMIT,
  input  logic                 FD_INDEX_IN,
  acq_controller_if.master     bus,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 RAM_FULL,
  output logic                 ABORTED,
  output logic [ADDR_BITS:0]   WORD_COUNT,
  output logic [IDX_BITS-1:0]  INDEX_SEEN
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_IDX,
    S_ACQUIRE,
    S_DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

  state_t               state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS:0]   word_count_q;
  logic [IDX_BITS-1:0]  index_seen_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ram_full_q;
  logic                 aborted_q;
  logic                 mdr_run_q;
  logic                 ram_we_q;
  logic [ADDR_BITS-1:0] ram_addr_q;
  logic [BITS-1:0]      ram_data_q;

  // FD_INDEX_IN is asynchronous to CLOCK: two flops before any logic sees it.
  logic [1:0] idx_sync;
  logic       idx_prev;
  logic       idx_rise;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_sync <= 2'b00;
      idx_prev <= 1'b0;
    end else begin
      idx_sync <= {idx_sync[0], FD_INDEX_IN};
      idx_prev <= idx_sync[1];
    end
  end

  assign idx_rise = idx_sync[1] & ~idx_prev;

  // Per-write decisions, all based on the word currently presented.
  logic                word_is_index;
  logic                limit_hit;
  logic                addr_full;
  logic [IDX_BITS-1:0] index_seen_next;
  logic                write_stop;

  assign word_is_index   = bus.MDR_DATA[BITS-2];
  assign limit_hit       = (INDEX_LIMIT != '0) && word_is_index &&
                           (IDX_BITS'(index_seen_q + 1'b1) == INDEX_LIMIT);
  assign addr_full       = (addr_q == ADDR_MAX);
  assign index_seen_next = (word_is_index && (index_seen_q != '1))
                           ? IDX_BITS'(index_seen_q + 1'b1) : index_seen_q;
  assign write_stop      = bus.MDR_WRITE && (limit_hit || addr_full);

  // NOTE: every register here uses <= so all branches see the same
  // pre-edge values; a blocking assignment would leak updates between them.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      word_count_q <= '0;
      index_seen_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ram_full_q   <= 1'b0;
      aborted_q    <= 1'b0;
      mdr_run_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
    end else begin
      ram_we_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          // ABORT alongside START cancels the start and leaves status intact.
          if (START && !ABORT) begin
            addr_q       <= '0;
            word_count_q <= '0;
            index_seen_q <= '0;
            done_q       <= 1'b0;
            ram_full_q   <= 1'b0;
            aborted_q    <= 1'b0;
            ram_addr_q   <= '0;
            busy_q       <= 1'b1;
            if (WAIT_INDEX) begin
              state     <= S_WAIT_IDX;
              mdr_run_q <= 1'b0;
            end else begin
              state     <= S_ACQUIRE;
              mdr_run_q <= 1'b1;
            end
          end
        end

        S_WAIT_IDX: begin
          if (ABORT) begin
            state     <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (idx_rise) begin
            state     <= S_ACQUIRE;
            mdr_run_q <= 1'b1;
          end
        end

        S_ACQUIRE: begin
          if (bus.MDR_WRITE) begin
            ram_we_q     <= 1'b1;
            ram_data_q   <= bus.MDR_DATA;
            ram_addr_q   <= addr_q;
            word_count_q <= word_count_q + 1'b1;
            index_seen_q <= index_seen_next;
            if (addr_full) begin
              ram_full_q <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          if (ABORT || write_stop) begin
            state     <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            mdr_run_q <= 1'b0;
            if (ABORT) begin
              aborted_q <= 1'b1;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          busy_q    <= 1'b0;
          mdr_run_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MDR_RUN  = mdr_run_q;
  assign bus.RAM_WE   = ram_we_q;
  assign bus.RAM_ADDR = ram_addr_q;
  assign bus.RAM_DATA = ram_data_q;

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign RAM_FULL   = ram_full_q;
  assign ABORTED    = aborted_q;
  assign WORD_COUNT = word_count_q;
  assign INDEX_SEEN = index_seen_q;

endmodule

// File: tb/tb_acq_controller.sv
// Scoreboard bench for acq_controller with a 16-entry RAM so the full
// condition is reachable; expected RAM writes are queued by the stimulus.
module tb_acq_controller;

  localparam int BITS      = 16;
  localparam int ADDR_BITS = 4;
  localparam int IDX_BITS  = 8;

  logic                CLOCK;
  logic                RESET_N;
  logic                START;
  logic                ABORT;
  logic                WAIT_INDEX;
  logic [IDX_BITS-1:0] INDEX_LIMIT;
  logic                FD_INDEX_IN;
  logic                BUSY;
  logic                DONE;
  logic                RAM_FULL;
  logic                ABORTED;
  logic [ADDR_BITS:0]  WORD_COUNT;
  logic [IDX_BITS-1:0] INDEX_SEEN;

  acq_controller_if #(.BITS(BITS), .ADDR_BITS(ADDR_BITS)) bus ();

  acq_controller #(.BITS(BITS), .ADDR_BITS(ADDR_BITS), .IDX_BITS(IDX_BITS)) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .START       (START),
    .ABORT       (ABORT),
    .WAIT_INDEX  (WAIT_INDEX),
    .INDEX_LIMIT (INDEX_LIMIT),
    .FD_INDEX_IN (FD_INDEX_IN),
    .bus         (bus.master),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .RAM_FULL    (RAM_FULL),
    .ABORTED     (ABORTED),
    .WORD_COUNT  (WORD_COUNT),
    .INDEX_SEEN  (INDEX_SEEN)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [BITS-1:0]      data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every RAM write must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (bus.RAM_WE === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ram_we_unexpected actual addr %0h data %0h required no write",
                   bus.RAM_ADDR, bus.RAM_DATA);
        end else begin
          mon_e = exp_q.pop_front();
          check("ram_addr", 32'(bus.RAM_ADDR), 32'(mon_e.addr));
          check("ram_data", 32'(bus.RAM_DATA), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic pulse_start(input logic wait_idx);
    START      = 1'b1;
    WAIT_INDEX = wait_idx;
    tick();
    START      = 1'b0;
  endtask

  task automatic pulse_abort();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
  endtask

  task automatic write_word(input logic [BITS-1:0] data, input logic accept,
                            input logic [ADDR_BITS-1:0] addr);
    exp_t e;
    if (accept) begin
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
    end
    bus.MDR_DATA  = data;
    bus.MDR_WRITE = 1'b1;
    tick();
    bus.MDR_WRITE = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_run"},   32'(bus.MDR_RUN),  0);
    check({tag, "_we"},    32'(bus.RAM_WE),   0);
    check({tag, "_addr"},  32'(bus.RAM_ADDR), 0);
    check({tag, "_data"},  32'(bus.RAM_DATA), 0);
    check({tag, "_busy"},  32'(BUSY),         0);
    check({tag, "_done"},  32'(DONE),         0);
    check({tag, "_full"},  32'(RAM_FULL),     0);
    check({tag, "_abrt"},  32'(ABORTED),      0);
    check({tag, "_count"}, 32'(WORD_COUNT),   0);
    check({tag, "_seen"},  32'(INDEX_SEEN),   0);
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    RESET_N       = 1'b0;
    START         = 1'b0;
    ABORT         = 1'b0;
    WAIT_INDEX    = 1'b0;
    INDEX_LIMIT   = '0;
    FD_INDEX_IN   = 1'b0;
    bus.MDR_DATA  = '0;
    bus.MDR_WRITE = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    RESET_N = 1'b1;
    tick();

    // Immediate start, 5 words, then ABORT.
    pulse_start(1'b0);
    check("imm_busy", 32'(BUSY), 1);
    check("imm_run", 32'(bus.MDR_RUN), 1);
    for (int i = 0; i < 5; i++) begin
      write_word(16'h0010 + 16'(i), 1'b1, 4'(i));
    end
    pulse_abort();
    check("imm_aborted", 32'(ABORTED), 1);
    check("imm_done", 32'(DONE), 1);
    check("imm_count", 32'(WORD_COUNT), 5);
    check("imm_run_off", 32'(bus.MDR_RUN), 0);
    check("imm_busy_off", 32'(BUSY), 0);
    write_word(16'h0099, 1'b0, '0);
    pulse_abort();
    tick();
    check("done_count_hold", 32'(WORD_COUNT), 5);
    check("done_abort_hold", 32'(ABORTED), 1);

    // Wait for index: strobes before the edge are discarded.
    pulse_start(1'b1);
    for (int i = 0; i < 3; i++) begin
      write_word(16'h0AA0 + 16'(i), 1'b0, '0);
    end
    check("wait_run", 32'(bus.MDR_RUN), 0);
    check("wait_busy", 32'(BUSY), 1);
    check("wait_count", 32'(WORD_COUNT), 0);
    check("wait_aborted_clr", 32'(ABORTED), 0);
    FD_INDEX_IN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.MDR_RUN === 1'b1) break;
      tick();
    end
    check("idx_run", 32'(bus.MDR_RUN), 1);
    check("idx_busy", 32'(BUSY), 1);
    write_word(16'h4001, 1'b1, 4'd0);
    check("idx_seen1", 32'(INDEX_SEEN), 1);
    pulse_abort();
    FD_INDEX_IN = 1'b0;
    check("idx_aborted", 32'(ABORTED), 1);

    // Index limit of 2: fourth word is the second index word and stops.
    INDEX_LIMIT = 8'd2;
    pulse_start(1'b0);
    write_word(16'h0100, 1'b1, 4'd0);
    write_word(16'h4100, 1'b1, 4'd1);
    write_word(16'h0050, 1'b1, 4'd2);
    check("lim_busy_mid", 32'(BUSY), 1);
    write_word(16'h4200, 1'b1, 4'd3);
    write_word(16'h0030, 1'b0, '0);
    check("lim_seen", 32'(INDEX_SEEN), 2);
    check("lim_done", 32'(DONE), 1);
    check("lim_count", 32'(WORD_COUNT), 4);
    check("lim_aborted", 32'(ABORTED), 0);
    check("lim_full", 32'(RAM_FULL), 0);
    check("lim_run", 32'(bus.MDR_RUN), 0);

    // RAM full at 16 words; START while acquiring is ignored.
    INDEX_LIMIT = '0;
    pulse_start(1'b0);
    check("full_count_clr", 32'(WORD_COUNT), 0);
    for (int i = 0; i < 3; i++) begin
      write_word(16'h1000 + 16'(i), 1'b1, 4'(i));
    end
    pulse_start(1'b0);
    check("busy_start_count", 32'(WORD_COUNT), 3);
    check("busy_start_busy", 32'(BUSY), 1);
    for (int i = 3; i < 16; i++) begin
      write_word(16'h1000 + 16'(i), 1'b1, 4'(i));
    end
    write_word(16'h1FFF, 1'b0, '0);
    check("full_flag", 32'(RAM_FULL), 1);
    check("full_done", 32'(DONE), 1);
    check("full_count", 32'(WORD_COUNT), 16);
    check("full_addr", 32'(bus.RAM_ADDR), 15);
    tick();
    tick();
    check("full_addr_hold", 32'(bus.RAM_ADDR), 15);
    check("full_run", 32'(bus.MDR_RUN), 0);

    // Reset in the middle of an acquisition.
    pulse_start(1'b0);
    write_word(16'h0111, 1'b1, 4'd0);
    write_word(16'h0222, 1'b1, 4'd1);
    tick();
    RESET_N = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    RESET_N = 1'b1;
    tick();

    // START with ABORT from IDLE: nothing happens.
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    check("sa_busy", 32'(BUSY), 0);
    check("sa_run", 32'(bus.MDR_RUN), 0);
    check("sa_done", 32'(DONE), 0);

    pulse_start(1'b0);
    write_word(16'h0077, 1'b1, 4'd0);
    write_word(16'h0078, 1'b1, 4'd1);
    pulse_abort();
    check("rst_restart_count", 32'(WORD_COUNT), 2);
    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acq_controller.md
Name: acq_controller

Overview:
- Sequences one magnetic disc acquisition around the disc reader (flux-interval counter).
- Arms on a host START command and optionally waits for an index pulse before enabling the reader's RUN.
- Streams reader words into acquisition RAM through an auto-incrementing address, and counts index-flagged words.
- Stops on revolution limit, RAM full or host ABORT, and holds status for the host register interface.

Parameters:
BITS, 16, reader word width; bit BITS-2 = index flag, bit BITS-1 = data flag
ADDR_BITS, 19, acquisition RAM address width
IDX_BITS, 8, width of index-limit and index counters

Ports:
CLOCK  in  1  system clock, all logic on rising edge
RESET_N  in  1  asynchronous, active-low reset
START  in  1  one-cycle acquisition start strobe
ABORT  in  1  one-cycle abort strobe
WAIT_INDEX  in  1  1 = start on next index rising edge; 0 = start immediately
INDEX_LIMIT  in  IDX_BITS  index-flagged words to capture before stopping; 0 = no limit
FD_INDEX_IN  in  1  raw index pulse from drive, asynchronous
MDR_RUN  out  1  run enable to disc reader
MDR_DATA  in  BITS  reader data word
MDR_WRITE  in  1  reader word-valid strobe
RAM_ADDR  out  ADDR_BITS  RAM write address
RAM_DATA  out  BITS  RAM write data
RAM_WE  out  1  RAM write enable
BUSY  out  1  state is WAIT_IDX or ACQUIRE
DONE  out  1  sticky, acquisition finished
RAM_FULL  out  1  sticky, stopped because RAM full
ABORTED  out  1  sticky, stopped by ABORT
WORD_COUNT  out  ADDR_BITS+1  words written this acquisition
INDEX_SEEN  out  IDX_BITS  index-flagged words written this acquisition

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE. All outputs 0, including MDR_RUN, RAM_*, flags and counters. Index synchroniser cleared.
- FD_INDEX_IN passes through a 2-flop synchroniser, then a rising-edge detector (idx_rise, one cycle wide).
- States: IDLE, WAIT_IDX, ACQUIRE, DONE.
- IDLE/DONE + START (and no ABORT):
  - Clear address, WORD_COUNT, INDEX_SEEN, DONE, RAM_FULL, ABORTED.
  - Go to WAIT_IDX if WAIT_INDEX=1, else go to ACQUIRE.
- START while BUSY: ignored.
- ABORT in IDLE or DONE: no effect. START+ABORT in the same cycle from IDLE/DONE: ABORT wins, stay put, flags untouched.
- WAIT_IDX:
  - idx_rise -> ACQUIRE.
  - ABORT -> DONE with ABORTED=1 and DONE=1.
  - MDR_RUN stays 0.
- ACQUIRE:
  - MDR_RUN=1, registered, asserted the cycle after entry.
  - Each MDR_WRITE produces, next cycle: RAM_WE=1 for one cycle, RAM_DATA=MDR_DATA, RAM_ADDR=current address. The address then increments. Latency is 1 clock.
  - If the written word has MDR_DATA[BITS-2]=1, INDEX_SEEN increments (saturates at all-ones).
  - Stop conditions, evaluated on the same write:
    - INDEX_LIMIT!=0 and INDEX_SEEN+1==INDEX_LIMIT.
    - Address == 2^ADDR_BITS-1, which sets RAM_FULL.
  - On any stop: the word is still written, then the state goes to DONE and DONE=1.
  - Both stop conditions on one write: set both results.
  - ABORT in ACQUIRE: any MDR_WRITE in the same cycle is still written. Then go to DONE with ABORTED=1.
- DONE: MDR_RUN=0 from the cycle DONE is entered. RAM_ADDR holds its value and does not wrap. Flags hold until the next START.
- MDR_WRITE outside ACQUIRE, including the reader's trailing write after RUN drops: discarded, RAM_WE stays 0.
- WORD_COUNT equals the number of RAM_WE pulses since START; it reaches 2^ADDR_BITS on full.
- RAM_WE never asserts twice for the same address within one acquisition.

Test Plan:
- Immediate start, INDEX_LIMIT=0, 5 writes with MDR_DATA 0x0010..0x0014, then ABORT -> RAM_WE at addresses 0..4 with matching data; ABORTED=1, DONE=1, WORD_COUNT=5, MDR_RUN=0.
- WAIT_INDEX=1: MDR_WRITE strobes before the index -> no RAM_WE, MDR_RUN=0. FD_INDEX_IN rises -> MDR_RUN=1 within 4 clocks of the edge; BUSY=1 throughout.
- INDEX_LIMIT=2: writes 0x0100, 0x4100 (index), 0x0050, 0x4200 (index), then 0x0030 -> 4 RAM writes, INDEX_SEEN=2, DONE=1; 5th word discarded.
- ADDR_BITS=4: 17 writes with no index -> 16 RAM writes at 0..15, RAM_FULL=1, WORD_COUNT=16, RAM_ADDR stays 15.
- RESET_N pulled low mid-ACQUIRE -> all outputs 0 immediately. After release, START with WAIT_INDEX=0 -> writes again begin at address 0.
- START+ABORT same cycle in IDLE -> stays IDLE, BUSY=0. START while in ACQUIRE -> counters not cleared.
